// File: rtl/matrix_display_ctrl.sv
// Cycles matrix-multiplier result elements onto a 4-digit multiplexed 7-segment display.
// Optional build macro: DISPLAY_BLANK_LEADING_ZERO_EN blanks digits above the most significant nonzero digit.
module matrix_display_ctrl #(
    parameter int CLK_DIV_BITS = 9,
    parameter int N_ELEM       = 4,
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 10,
    parameter int DWELL_TICKS  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    output logic              elem_rd_en,
    output logic [ADDR_W-1:0] elem_rd_addr,
    input  logic [DATA_W-1:0] elem_rd_data,
    output logic [3:0]        an,
    output logic [6:0]        seg,
    output logic              dp,
    output logic              busy
);

    localparam int CNT_W   = $clog2(DATA_W + 1);
    localparam int DWELL_W = (DWELL_TICKS > 1) ? $clog2(DWELL_TICKS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CONVERT = 3'd3,
        ST_SHOW    = 3'd4
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [CLK_DIV_BITS-1:0] presc_r;
    logic                scan_tick_s;
    logic [1:0]          idx_r, idx_nxt_s;
    logic [ADDR_W-1:0]   addr_r, addr_nxt_s;
    logic [DATA_W-1:0]   sr_r, sr_nxt_s;
    logic [15:0]         bcd_r, bcd_nxt_s, bcd_adj_s, bcd_step_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
    logic [DWELL_W-1:0]  dwell_r, dwell_nxt_s;
    logic [15:0]         disp_r, disp_nxt_s;
    logic                valid_r, valid_nxt_s;
    logic                digit_on_s;
    logic [3:0]          nib_s;
    logic [3:0]          an_nxt_s, an_r;
    logic [6:0]          seg_nxt_s, seg_r;
    logic                dp_r, busy_r, rd_en_r;

    function automatic logic [15:0] dd_adjust(input logic [15:0] v);
        logic [15:0] r;
        r = v;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end else begin
                r[i*4 +: 4] = r[i*4 +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    assign scan_tick_s = &presc_r;
    assign idx_nxt_s   = scan_tick_s ? (idx_r + 2'd1) : idx_r;
    assign bcd_adj_s   = dd_adjust(bcd_r);
    assign bcd_step_s  = {bcd_adj_s[14:0], sr_r[DATA_W-1]};

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath next values; stop overrides every state
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_r;
        sr_nxt_s    = sr_r;
        bcd_nxt_s   = bcd_r;
        cnt_nxt_s   = cnt_r;
        dwell_nxt_s = dwell_r;
        disp_nxt_s  = disp_r;
        valid_nxt_s = valid_r;
        if (stop) begin
            state_nxt_s = ST_IDLE;
            addr_nxt_s  = '0;
            valid_nxt_s = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    valid_nxt_s = 1'b0;
                    if (start) begin
                        state_nxt_s = ST_FETCH;
                        addr_nxt_s  = '0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    state_nxt_s = ST_WAIT;
                end
                ST_WAIT: begin
                    sr_nxt_s    = elem_rd_data;
                    bcd_nxt_s   = 16'h0000;
                    cnt_nxt_s   = '0;
                    state_nxt_s = ST_CONVERT;
                end
                ST_CONVERT: begin
                    bcd_nxt_s = bcd_step_s;
                    sr_nxt_s  = sr_r << 1;
                    if (cnt_r == CNT_W'(DATA_W - 1)) begin
                        state_nxt_s = ST_SHOW;
                        disp_nxt_s  = bcd_step_s;
                        valid_nxt_s = 1'b1;
                        dwell_nxt_s = '0;
                    end else begin
                        cnt_nxt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (scan_tick_s) begin
                        if (dwell_r == DWELL_W'(DWELL_TICKS - 1)) begin
                            state_nxt_s = ST_FETCH;
                            addr_nxt_s  = (addr_r == ADDR_W'(N_ELEM - 1)) ? '0 : (addr_r + ADDR_W'(1));
                        end else begin
                            dwell_nxt_s = dwell_r + DWELL_W'(1);
                        end
                    end else begin
                        dwell_nxt_s = dwell_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // Drive an/seg from next-cycle values so new digits appear on the same edge they are loaded
    always_comb begin
        an_nxt_s  = 4'b1111;
        seg_nxt_s = 7'h7F;
        nib_s     = disp_nxt_s[{idx_nxt_s, 2'b00} +: 4];
`ifdef DISPLAY_BLANK_LEADING_ZERO_EN
        case (idx_nxt_s)
            2'd0:    digit_on_s = 1'b1;
            2'd1:    digit_on_s = |disp_nxt_s[15:4];
            2'd2:    digit_on_s = |disp_nxt_s[15:8];
            2'd3:    digit_on_s = |disp_nxt_s[15:12];
            default: digit_on_s = 1'b1;
        endcase
`else
        digit_on_s = 1'b1;
`endif
        if (valid_nxt_s && digit_on_s) begin
            an_nxt_s  = ~(4'b0001 << idx_nxt_s);
            seg_nxt_s = seg7(nib_s);
        end else begin
            an_nxt_s  = 4'b1111;
            seg_nxt_s = 7'h7F;
        end
    end

    // Datapath, prescaler, scan index and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
            idx_r   <= 2'd0;
            addr_r  <= '0;
            sr_r    <= '0;
            bcd_r   <= 16'h0000;
            cnt_r   <= '0;
            dwell_r <= '0;
            disp_r  <= 16'h0000;
            valid_r <= 1'b0;
            an_r    <= 4'b1111;
            seg_r   <= 7'h7F;
            dp_r    <= 1'b1;
            busy_r  <= 1'b0;
            rd_en_r <= 1'b0;
        end else begin
            presc_r <= presc_r + CLK_DIV_BITS'(1);
            idx_r   <= idx_nxt_s;
            addr_r  <= addr_nxt_s;
            sr_r    <= sr_nxt_s;
            bcd_r   <= bcd_nxt_s;
            cnt_r   <= cnt_nxt_s;
            dwell_r <= dwell_nxt_s;
            disp_r  <= disp_nxt_s;
            valid_r <= valid_nxt_s;
            an_r    <= an_nxt_s;
            seg_r   <= seg_nxt_s;
            dp_r    <= 1'b1;
            busy_r  <= (state_nxt_s != ST_IDLE);
            rd_en_r <= (state_nxt_s == ST_FETCH);
        end
    end

    assign elem_rd_en   = rd_en_r;
    assign elem_rd_addr = addr_r;
    assign an           = an_r;
    assign seg          = seg_r;
    assign dp           = dp_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_matrix_display_ctrl.sv
// Scoreboard bench for matrix_display_ctrl: expected read addresses and displayed values are queued
// by the stimulus and consumed by a monitor that watches read strobes and the scanned display.
module tb_matrix_display_ctrl;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 2;
    localparam logic [DATA_W-1:0] GARBAGE = 10'h2AA;

    logic              clk;
    logic              rst;
    logic              start;
    logic              stop;
    logic              elem_rd_en;
    logic [ADDR_W-1:0] elem_rd_addr;
    logic [DATA_W-1:0] elem_rd_data;
    logic [3:0]        an;
    logic [6:0]        seg;
    logic              dp;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;
    int rd_seen  = 0;
    bit stop_req = 1'b0;

    int exp_addr_q[$];
    int exp_disp_q[$];

    int store [4] = '{42, 1023, 0, 999};
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int p10 [4] = '{1, 10, 100, 1000};

    matrix_display_ctrl #(
        .CLK_DIV_BITS(2),
        .N_ELEM(4),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .DWELL_TICKS(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .elem_rd_en(elem_rd_en),
        .elem_rd_addr(elem_rd_addr),
        .elem_rd_data(elem_rd_data),
        .an(an),
        .seg(seg),
        .dp(dp),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Result store: data valid only in the cycle after the read strobe
    initial begin
        bit rd_pend;
        int rd_a;
        rd_pend = 1'b0;
        rd_a = 0;
        elem_rd_data = GARBAGE;
        forever begin
            @(posedge clk);
            #1;
            if (rd_pend) begin
                elem_rd_data = DATA_W'(store[rd_a]);
                rd_pend = 1'b0;
            end else begin
                elem_rd_data = GARBAGE;
            end
            if (elem_rd_en === 1'b1) begin
                rd_pend = 1'b1;
                rd_a = int'(elem_rd_addr);
            end
        end
    end

    // Monitor: pairs read strobes with queued addresses and checks the scanned display
    initial begin
        int presc_m, idx_m, pend, cur_val;
        bit cur_valid, shown;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        presc_m = 0; idx_m = 0; pend = 0; cur_val = 0; cur_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b1) begin
                presc_m = 0; idx_m = 0; pend = 0; cur_valid = 1'b0;
            end else begin
                if (presc_m == 3) idx_m = (idx_m + 1) % 4;
                presc_m = (presc_m + 1) % 4;
                if (stop_req) begin
                    cur_valid = 1'b0;
                    pend = 0;
                    stop_req = 1'b0;
                end
                if (elem_rd_en === 1'b1) begin
                    rd_seen++;
                    if (exp_addr_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL rd_unexpected: got read strobe addr %0d expected none", elem_rd_addr);
                    end else begin
                        check("rd_addr", 32'(elem_rd_addr), 32'(exp_addr_q.pop_front()));
                    end
                    pend = 12;
                end else if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        if (exp_disp_q.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL disp_unexpected: got new element shown expected none");
                        end else begin
                            cur_val = exp_disp_q.pop_front();
                            cur_valid = 1'b1;
                        end
                    end
                end
            end
            exp_an = 4'b1111;
            exp_seg = 7'h7F;
            if (cur_valid) begin
`ifdef DISPLAY_BLANK_LEADING_ZERO_EN
                shown = (idx_m == 0) || (cur_val >= p10[idx_m]);
`else
                shown = 1'b1;
`endif
                if (shown) begin
                    exp_an = ~(4'b0001 << idx_m);
                    exp_seg = seg_tab[(cur_val / p10[idx_m]) % 10];
                end
            end
            check("an", 32'(an), 32'(exp_an));
            check("seg", 32'(seg), 32'(exp_seg));
            check("dp", 32'(dp), 32'd1);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        stop_req = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    task automatic wait_rd(input int n);
        int k;
        k = 0;
        while (rd_seen < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("rd_wait_timeout", 32'(rd_seen >= n), 32'd1);
    endtask

    // Directed stimulus
    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_addr", 32'(elem_rd_addr), 32'd0);
        check("idle_rd_en", 32'(elem_rd_en), 32'd0);

        // Full cycle through all elements and wrap back to 0
        exp_addr_q = '{0, 1, 2, 3, 0};
        exp_disp_q = '{42, 1023, 0, 999, 42};
        pulse_start();
        wait_rd(1);
        check("run_busy", 32'(busy), 32'd1);
        wait_rd(5);
        repeat (13) @(negedge clk);
        do_stop();
        check("stop_busy", 32'(busy), 32'd0);

        // Stop while element 2 is converting, then restart from element 0
        exp_addr_q = '{0, 1, 2};
        exp_disp_q = '{42, 1023};
        pulse_start();
        wait_rd(8);
        repeat (4) @(negedge clk);
        do_stop();
        check("conv_stop_busy", 32'(busy), 32'd0);
        check("conv_stop_addr", 32'(elem_rd_addr), 32'd0);
        repeat (20) @(negedge clk);
        exp_addr_q = '{0};
        exp_disp_q = '{42};
        pulse_start();
        wait_rd(9);
        repeat (13) @(negedge clk);
        do_stop();

        // Start and stop together from IDLE: stop wins
        start = 1'b1;
        stop = 1'b1;
        stop_req = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        check("start_stop_busy", 32'(busy), 32'd0);
        repeat (20) @(negedge clk);

        // Start pulse during SHOW must not restart the sequence
        exp_addr_q = '{0, 1};
        exp_disp_q = '{42, 1023};
        pulse_start();
        wait_rd(10);
        repeat (13) @(negedge clk);
        pulse_start();
        wait_rd(11);
        repeat (13) @(negedge clk);
        do_stop();

        // Reset mid-operation
        exp_addr_q = '{0};
        exp_disp_q = '{42};
        pulse_start();
        wait_rd(12);
        repeat (13) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd_en", 32'(elem_rd_en), 32'd0);
        repeat (12) @(negedge clk);

        check("addr_q_empty", 32'(exp_addr_q.size()), 32'd0);
        check("disp_q_empty", 32'(exp_disp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
